// File: rtl/wb_line_buf.sv
// Single-line read buffer between a Wishbone CPU slave port and the sdram_ctrl master port.
// Optional hit/miss counters are built when WB_LINE_BUF_STATS_EN is defined.
module wb_line_buf #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        S_CYC,
  input  logic        S_STB,
  input  logic        S_WE,
  input  logic [31:0] S_ADR,
  input  logic [31:0] S_DAT_O,
  output logic [31:0] S_DAT_I,
  output logic        S_ACK,
  output logic        S_ERR,
  output logic        M_CYC,
  output logic        M_STB,
  output logic        M_WE,
  output logic [31:0] M_ADR,
  output logic [31:0] M_DAT_O,
  output logic [2:0]  M_CTI_O,
  input  logic [31:0] M_DAT_I,
  input  logic        M_ACK,
  input  logic        M_ERR
`ifdef WB_LINE_BUF_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, HIT_RSP, FILL, FILL_RSP, WRITE} state_t;

  state_t            state_reg, state_next;
  logic              valid_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [IDX_W-1:0]  beat_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [31:0]       adr_reg;
  logic [31:0]       wdat_reg;
  logic [31:0]       rdata_reg;
  logic              abort_reg;
  logic [31:0]       words [LINE_WORDS];

  logic              req;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              hit;
  logic              last_beat;
  logic              bus_ack;
  logic              bus_err;
  logic              write_hit;

  assign req       = S_CYC && S_STB;
  assign req_tag   = S_ADR[31 -: TAG_W];
  assign req_idx   = S_ADR[2 +: IDX_W];
  assign hit       = valid_reg && (tag_reg == req_tag);
  assign last_beat = (beat_reg == LAST_BEAT);
  // Simultaneous ACK and ERR from memory is treated as an error.
  assign bus_err   = M_ERR;
  assign bus_ack   = M_ACK && !M_ERR;
  assign write_hit = valid_reg && (tag_reg == adr_reg[31 -: TAG_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    S_ACK      = 1'b0;
    S_ERR      = 1'b0;
    S_DAT_I    = 32'd0;
    M_CYC      = 1'b0;
    M_STB      = 1'b0;
    M_WE       = 1'b0;
    M_ADR      = 32'd0;
    M_DAT_O    = 32'd0;
    M_CTI_O    = 3'b000;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (S_WE)     state_next = WRITE;
          else if (hit) state_next = HIT_RSP;
          else          state_next = FILL;
        end
      end
      HIT_RSP: begin
        S_ACK      = 1'b1;
        S_DAT_I    = rdata_reg;
        state_next = IDLE;
      end
      FILL: begin
        M_CYC   = 1'b1;
        M_STB   = 1'b1;
        M_ADR   = {tag_reg, beat_reg, 2'b00};
        M_CTI_O = last_beat ? 3'b111 : 3'b010;
        if (bus_err) begin
          // A master that already walked away gets no error either.
          S_ERR      = !(abort_reg || !S_CYC);
          state_next = IDLE;
        end else if (bus_ack && last_beat) begin
          state_next = FILL_RSP;
        end
      end
      FILL_RSP: begin
        S_ACK      = !abort_reg;
        S_DAT_I    = abort_reg ? 32'd0 : rdata_reg;
        state_next = IDLE;
      end
      WRITE: begin
        M_CYC   = 1'b1;
        M_STB   = 1'b1;
        M_WE    = 1'b1;
        M_ADR   = adr_reg;
        M_DAT_O = wdat_reg;
        if (bus_err) begin
          S_ERR      = 1'b1;
          state_next = IDLE;
        end else if (bus_ack) begin
          S_ACK      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      beat_reg  <= '0;
      idx_reg   <= '0;
      adr_reg   <= 32'd0;
      wdat_reg  <= 32'd0;
      rdata_reg <= 32'd0;
      abort_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            adr_reg   <= S_ADR;
            wdat_reg  <= S_DAT_O;
            idx_reg   <= req_idx;
            abort_reg <= 1'b0;
            if (!S_WE) begin
              if (hit) begin
                rdata_reg <= words[req_idx];
              end else begin
                valid_reg <= 1'b0;
                tag_reg   <= req_tag;
                beat_reg  <= '0;
              end
            end
          end
        end
        FILL: begin
          if (!S_CYC) abort_reg <= 1'b1;
          if (bus_err) begin
            beat_reg <= '0;
          end else if (bus_ack) begin
            beat_reg <= beat_reg + IDX_W'(1);
            if (beat_reg == idx_reg) rdata_reg <= M_DAT_I;
            if (last_beat) valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (state_reg == FILL && bus_ack) begin
      words[beat_reg] <= M_DAT_I;
    end else if (state_reg == WRITE && bus_ack && write_hit) begin
      words[adr_reg[2 +: IDX_W]] <= wdat_reg;
    end
  end

`ifdef WB_LINE_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (state_reg == IDLE && req && !S_WE) begin
      if (hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
